apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter_pkg.sv | 13 +
 rtl/apb_req_arbiter_rr_arb2.sv | 11 +
 rtl/apb_req_arbiter.sv | 121 ++++++++++++
 tb/tb_apb_req_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_req_arbiter_pkg.sv
// rtl/apb_req_arbiter_pkg.sv - shared APB state type and default bus widths
package apb_req_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam int APB_ADDR_W = 8;
   localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_req_arbiter_rr_arb2.sv
// rtl/apb_req_arbiter_rr_arb2.sv - two-way round-robin grant, ties go to the non-last owner
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   output logic grant
);

   assign grant = (req0 && req1) ? ~last_owner : req1;

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester APB master; optional PREADY timeout via APB_TIMEOUT_EN
module apb_req_arbiter
   import apb_req_arbiter_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req0,
   input  logic              req1,
   input  logic              wr0,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done0,
   output logic              done1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic [DATA_W-1:0] PRDATA
);

   apb_state_t state;
   logic       owner;
   logic       grant;
   logic       timeout;
   logic       xfer_end;

   rr_arb2 u_rr_arb2 (
      .req0       (req0),
      .req1       (req1),
      .last_owner (owner),
      .grant      (grant)
   );

   assign xfer_end = (state == ACCESS) && (PREADY || timeout);
   assign done0    = xfer_end && !owner;
   assign done1    = xfer_end && owner;
   assign rdata    = PRDATA;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;

   // A slave that raises PREADY on the limit cycle still completes normally.
   assign timeout = (state == ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
   assign err0    = timeout && !owner;
   assign err1    = timeout && owner;

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         wait_cnt <= '0;
      end else if (state == IDLE && (req0 || req1)) begin
         wait_cnt <= '0;
      end else if (state == ACCESS && !PREADY && !timeout) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout            = 1'b0;
   assign err0               = 1'b0;
   assign err1               = 1'b0;
`endif

   // owner also serves as the last owner for the next tie-break; reset to 1 so requester 0 wins first.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state   <= IDLE;
         owner   <= 1'b1;
         PSEL    <= 1'b0;
         PENABLE <= 1'b0;
         PWRITE  <= 1'b0;
         PADDR   <= '0;
         PWDATA  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  state  <= SETUP;
                  PSEL   <= 1'b1;
                  owner  <= grant;
                  PWRITE <= grant ? wr1 : wr0;
                  PADDR  <= grant ? addr1 : addr0;
                  PWDATA <= grant ? wdata1 : wdata0;
               end
            end
            SETUP: begin
               state   <= ACCESS;
               PENABLE <= 1'b1;
            end
            ACCESS: begin
               if (xfer_end) begin
                  state   <= IDLE;
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - self-checking bench for apb_req_arbiter (timeout test with APB_TIMEOUT_EN)
module tb_apb_req_arbiter;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int TO     = 16;

   logic              PCLK = 1'b0;
   logic              PRESET = 1'b1;
   logic              req0, req1, wr0, wr1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              done0, done1, err0, err1;
   logic [DATA_W-1:0] rdata;
   logic              PSEL, PENABLE, PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic              PREADY;
   logic [DATA_W-1:0] PRDATA;

   int checks = 0;
   int errors = 0;

   apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .done0(done0), .done1(done1), .err0(err0), .err1(err1), .rdata(rdata),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PRDATA(PRDATA)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic drive_idle();
      req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      PREADY = 0; PRDATA = '0;
   endtask

   task automatic at_drive();
      @(posedge PCLK);
      #1;
   endtask

   task automatic at_sample();
      @(negedge PCLK);
   endtask

   task automatic do_reset();
      PRESET = 0;
      drive_idle();
      repeat (2) @(posedge PCLK);
      #1 PRESET = 1;
   endtask

   task automatic set_req(input int i, input logic r, input logic w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (i == 0) begin
         req0 = r; wr0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; wr1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic test_reset();
      drive_idle();
      #3 PRESET = 0;
      #2;
      checks++;
      if ({PSEL, PENABLE, PWRITE, done0, done1, err0, err1} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {PSEL, PENABLE, PWRITE, done0, done1, err0, err1});
      end
      checks++;
      if (PADDR !== '0 || PWDATA !== '0) begin
         errors++;
         $display("FAIL reset_bus: got PADDR=%h PWDATA=%h expected 0", PADDR, PWDATA);
      end
      repeat (2) @(posedge PCLK);
      #1 PRESET = 1;
   endtask

   task automatic test_single_write();
      set_req(0, 1, 1, 8'h10, 32'hDEADBEEF);
      PREADY = 1;
      at_sample();
      checks++;
      if (PSEL !== 0 || done0 !== 0) begin
         errors++;
         $display("FAIL wr_cycleN: got PSEL=%b done0=%b expected 0 0", PSEL, done0);
      end
      at_drive(); at_sample();
      checks++;
      if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 8'h10 || PWDATA !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_setup: got sel/en/wr=%b addr=%h data=%h expected 101 10 deadbeef",
                  {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
      end
      at_drive(); at_sample();
      checks++;
      if ({PSEL, PENABLE, done0, done1, err0} !== 5'b11100 || PWDATA !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_access: got sel/en/d0/d1/e0=%b data=%h expected 11100 deadbeef",
                  {PSEL, PENABLE, done0, done1, err0}, PWDATA);
      end
      at_drive();
      req0 = 0;
      at_sample();
      checks++;
      if (PSEL !== 0 || done0 !== 0) begin
         errors++;
         $display("FAIL wr_after: got PSEL=%b done0=%b expected 0 0", PSEL, done0);
      end
      at_drive();
   endtask

   task automatic test_round_robin();
      int order[$];
      int when[$];
      int cyc;
      do_reset();
      set_req(0, 1, 1, 8'h30, 32'h0000_0030);
      set_req(1, 1, 0, 8'h40, 32'h0000_0040);
      PREADY = 1;
      cyc = 0;
      while (order.size() < 4 && cyc < 40) begin
         at_sample();
         if (done0) begin order.push_back(0); when.push_back(cyc); end
         if (done1) begin order.push_back(1); when.push_back(cyc); end
         cyc++;
         at_drive();
      end
      req0 = 0; req1 = 0;
      checks++;
      if (order.size() != 4) begin
         errors++;
         $display("FAIL rr_count: got %0d transfers expected 4", order.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (order[k] != k % 2 || when[k] != 2 + 3 * k) begin
               errors++;
               $display("FAIL rr_order[%0d]: got owner %0d at cycle %0d expected owner %0d at cycle %0d",
                        k, order[k], when[k], k % 2, 2 + 3 * k);
            end
         end
      end
      at_drive();
   endtask

   task automatic test_read_wait();
      int waits, cyc;
      bit got;
      set_req(1, 1, 0, 8'h20, 32'h0);
      PRDATA = 32'h12345678;
      PREADY = 0;
      waits = 0; cyc = 0; got = 0;
      while (!got && cyc < 30) begin
         at_sample();
         if (done0) begin
            checks++; errors++;
            $display("FAIL rd_nonowner: got done0=1 expected 0");
         end
         if (done1) begin
            got = 1;
            checks++;
            if (waits != 3 || cyc != 5) begin
               errors++;
               $display("FAIL rd_wait: got %0d waits done at cycle %0d expected 3 waits cycle 5", waits, cyc);
            end
            checks++;
            if (rdata !== 32'h12345678 || PADDR !== 8'h20 || PWRITE !== 0) begin
               errors++;
               $display("FAIL rd_data: got rdata=%h addr=%h wr=%b expected 12345678 20 0", rdata, PADDR, PWRITE);
            end
         end else if (PENABLE) begin
            waits++;
         end
         cyc++;
         at_drive();
         if (waits == 3) PREADY = 1;
      end
      req1 = 0; PREADY = 0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL rd_done: got no done1 within 30 cycles expected done1");
      end
      at_drive();
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit got;
      set_req(0, 1, 1, 8'h55, 32'hA5A5_5A5A);
      PREADY = 0;
      at_sample(); at_drive(); at_sample(); at_drive(); at_sample();
      checks++;
      if (PENABLE !== 1) begin
         errors++;
         $display("FAIL rst_mid_pre: got PENABLE=%b expected 1", PENABLE);
      end
      #1 PRESET = 0;
      PREADY = 1;
      #1;
      checks++;
      if ({PSEL, PENABLE, PWRITE, done0, done1} !== 5'b0 || PADDR !== '0 || PWDATA !== '0) begin
         errors++;
         $display("FAIL rst_mid: got ctrl=%b addr=%h data=%h expected 0",
                  {PSEL, PENABLE, PWRITE, done0, done1}, PADDR, PWDATA);
      end
      at_drive();
      PRESET = 1;
      cyc = 0; got = 0;
      while (!got && cyc < 10) begin
         at_sample();
         if (done0) got = 1;
         else cyc++;
         at_drive();
      end
      req0 = 0;
      checks++;
      if (!got || cyc != 2) begin
         errors++;
         $display("FAIL rst_mid_after: got done=%b at cycle %0d expected done at cycle 2", got, cyc);
      end
      at_drive();
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout();
      int low, cyc;
      bit got;
      set_req(0, 1, 0, 8'h77, 32'h0);
      PREADY = 0;
      low = 0; cyc = 0; got = 0;
      while (!got && cyc < 40) begin
         at_sample();
         if (done0) begin
            got = 1;
            checks++;
            if (err0 !== 1 || err1 !== 0 || low != TO) begin
               errors++;
               $display("FAIL to_abort: got err0=%b err1=%b after %0d low cycles expected 1 0 after %0d",
                        err0, err1, low, TO);
            end
         end else if (PENABLE) begin
            low++;
         end
         cyc++;
         at_drive();
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL to_done: got no done0 within 40 cycles expected timeout");
      end
      set_req(0, 1, 1, 8'h78, 32'h1111_2222);
      PREADY = 1;
      cyc = 0; got = 0;
      while (!got && cyc < 10) begin
         at_sample();
         if (done0) begin
            got = 1;
            checks++;
            if (err0 !== 0 || cyc != 2) begin
               errors++;
               $display("FAIL to_next: got err0=%b at cycle %0d expected 0 at cycle 2", err0, cyc);
            end
         end
         cyc++;
         at_drive();
      end
      req0 = 0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL to_next_done: got no done0 expected done0");
      end
      at_drive();
   endtask
`endif

   // Model: g = cycles since grant (-1 when the bus is free); ACCESS is every g >= 1.
   task automatic test_random();
      int g;
      bit m_own, m_last, m_wr, to, fin[2], act[2];
      logic [ADDR_W-1:0] m_addr;
      logic [DATA_W-1:0] m_wd;
      logic [5:0] exp_v;
      bit exp_end;
      do_reset();
      g = -1; m_own = 0; m_last = 1; m_wr = 0; m_addr = '0; m_wd = '0;
      fin[0] = 0; fin[1] = 0; act[0] = 0; act[1] = 0;
      repeat (400) begin
         for (int i = 0; i < 2; i++) begin
            if (fin[i]) begin
               fin[i] = 0;
               if ($urandom % 2 == 0) set_req(i, 1, 1'($urandom), 8'($urandom), $urandom);
               else begin set_req(i, 0, 0, '0, '0); act[i] = 0; end
            end else if (!act[i]) begin
               if ($urandom % 3 == 0) begin
                  set_req(i, 1, 1'($urandom), 8'($urandom), $urandom);
                  act[i] = 1;
               end
            end else if (!(g >= 0 && int'(m_own) == i) && $urandom % 10 == 0) begin
               set_req(i, 0, 0, '0, '0);
               act[i] = 0;
            end
         end
         PREADY = 1'($urandom);
         PRDATA = $urandom;
         at_sample();
         to = 0;
`ifdef APB_TIMEOUT_EN
         to = (g >= 1) && !PREADY && (g - 1 == TO);
`endif
         exp_end = (g >= 1) && (PREADY || to);
         exp_v = {g >= 0, g >= 1, exp_end && !m_own, exp_end && m_own, to && !m_own, to && m_own};
         checks++;
         if ({PSEL, PENABLE, done0, done1, err0, err1} !== exp_v) begin
            errors++;
            $display("FAIL rand_ctrl: got sel/en/d0/d1/e0/e1=%b expected %b (g=%0d)",
                     {PSEL, PENABLE, done0, done1, err0, err1}, exp_v, g);
         end
         if (g >= 0) begin
            checks++;
            if (PWRITE !== m_wr || PADDR !== m_addr || PWDATA !== m_wd) begin
               errors++;
               $display("FAIL rand_cmd: got wr=%b addr=%h data=%h expected %b %h %h",
                        PWRITE, PADDR, PWDATA, m_wr, m_addr, m_wd);
            end
         end
         checks++;
         if (rdata !== PRDATA) begin
            errors++;
            $display("FAIL rand_rdata: got %h expected %h", rdata, PRDATA);
         end
         if (g < 0) begin
            if (req0 || req1) begin
               m_own  = (req0 && req1) ? !m_last : req1;
               m_last = m_own;
               m_wr   = m_own ? wr1 : wr0;
               m_addr = m_own ? addr1 : addr0;
               m_wd   = m_own ? wdata1 : wdata0;
               g = 0;
            end
         end else if (exp_end) begin
            fin[m_own] = 1;
            g = -1;
         end else begin
            g++;
         end
         at_drive();
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_single_write();
      test_round_robin();
      test_read_wait();
      test_reset_mid();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
